cdc_bus_sender: RTL and testbench

CDC_BUS_SENDER -- requirements
Module: cdc_bus_sender

---
 rtl/cdc_pkg.sv | 22 ++
 rtl/cdc_ack_sync.sv | 34 +++
 rtl/cdc_bus_sender.sv | 129 ++++++++++++
 tb/tb_cdc_bus_sender.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_pkg
//  Description : Shared types and constants for the CDC bus sender: the
//                handshake state encoding and the default ack synchronizer
//                depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package cdc_pkg;

    // Handshake phases of the 4-phase request/acknowledge protocol
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } cdc_state_e;

    // Default flop depth of the ack synchronizer
    localparam int c_sync_stages_default = 3;

endpackage
`default_nettype wire

// File: rtl/cdc_ack_sync.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_ack_sync
//  Description : Multi-flop level synchronizer that brings the destination
//                domain's acknowledge into the source clock domain.
//                SYNC_STAGES sets the depth (2..4).
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_ack_sync
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES = c_sync_stages_default
) (
    input  logic clk,
    input  logic arst,
    input  logic async_in,
    output logic sync_out
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

    // Shift the asynchronous level through the chain; stage 0 may go metastable
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cdc_bus_sender.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_bus_sender
//  Description : Source side of a 4-phase req/ack bus crossing. A word is
//                accepted in IDLE, held on xfer_data while xfer_req is high,
//                and done pulses once the synchronized ack has returned low.
//                Optional REQ-phase watchdog: define CDC_SENDER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_bus_sender
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SYNC_STAGES    = c_sync_stages_default,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  xfer_req,
    output logic [DATA_WIDTH-1:0] xfer_data,
    input  logic                  xfer_ack_async,
    output logic                  done,
    output logic                  timeout_err
);

    cdc_state_e            r_state;
    cdc_state_e            w_state_nxt;
    logic                  w_ack_sync;
    logic                  w_accept;
    logic                  w_timeout_hit;
    logic                  r_xfer_req;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_xfer_data;

    cdc_ack_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk      (clk),
        .arst     (arst),
        .async_in (xfer_ack_async),
        .sync_out (w_ack_sync)
    );

`ifdef CDC_SENDER_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_cnt_w-1:0] r_req_cnt;
    logic               r_timeout_err;

    // The last permitted REQ cycle ends without an ack: force the release
    assign w_timeout_hit = (r_state == REQ) && !w_ack_sync &&
                           (r_req_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

    // Count cycles spent in REQ; cleared in every other phase
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_req_cnt <= '0;
        end else if ((r_state == REQ) && !w_timeout_hit) begin
            r_req_cnt <= r_req_cnt + 1'b1;
        end else begin
            r_req_cnt <= '0;
        end
    end

    // Sticky error flag, only reset clears it
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout_hit) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout_cfg;

    // Without the watchdog REQ waits for the ack indefinitely
    assign w_timeout_hit        = 1'b0;
    assign timeout_err          = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // Next-state decode; a stale high ack holds IDLE so a new request never
    // overlaps the previous handshake's acknowledge
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid && !w_ack_sync)       w_state_nxt = REQ;
            REQ:     if (w_ack_sync || w_timeout_hit)   w_state_nxt = RELEASE;
            RELEASE: if (!w_ack_sync)                   w_state_nxt = IDLE;
            default:                                    w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = (r_state == IDLE) && (w_state_nxt == REQ);

    // State register with req/done registered from the next-state decode
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state    <= IDLE;
            r_xfer_req <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_xfer_req <= (w_state_nxt == REQ);
            r_done     <= (r_state == RELEASE) && (w_state_nxt == IDLE);
        end
    end

    // Data is captured only on accept so it stays stable across the handshake
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_xfer_data <= '0;
        end else if (w_accept) begin
            r_xfer_data <= in_data;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign xfer_req  = r_xfer_req;
    assign xfer_data = r_xfer_data;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cdc_bus_sender.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdc_bus_sender
//  Description : Self-checking bench for cdc_bus_sender (DATA_WIDTH=32,
//                SYNC_STAGES=3, TIMEOUT_CYCLES=16). A transaction-level
//                reference model predicts every output each cycle; directed
//                sequences pin latencies with literal expectations.
//                Follows CDC_SENDER_TIMEOUT_EN for the watchdog scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_bus_sender;

    localparam int c_ss = 3;
    localparam int c_to = 16;
`ifdef CDC_SENDER_TIMEOUT_EN
    localparam bit c_to_en = 1'b1;
`else
    localparam bit c_to_en = 1'b0;
`endif

    logic        clk            = 1'b0;
    logic        arst           = 1'b1;
    logic        in_valid       = 1'b0;
    logic [31:0] in_data        = 32'h0;
    logic        xfer_ack_async = 1'b0;
    logic        in_ready;
    logic        xfer_req;
    logic [31:0] xfer_data;
    logic        done;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    cdc_bus_sender #(
        .DATA_WIDTH     (32),
        .SYNC_STAGES    (c_ss),
        .TIMEOUT_CYCLES (c_to)
    ) dut (
        .clk            (clk),
        .arst           (arst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .xfer_req       (xfer_req),
        .xfer_data      (xfer_data),
        .xfer_ack_async (xfer_ack_async),
        .done           (done),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a handshake is "busy" from accept until the ack has
    // been seen high and then low again; the ack is seen c_ss edges late.
    // ------------------------------------------------------------------
    int          m_phase      = 0;   // 0 free, 1 waiting for ack, 2 waiting for ack low
    logic [31:0] m_word       = 32'h0;
    bit          m_done       = 1'b0;
    bit          m_err        = 1'b0;
    int          m_req_cycles = 0;
    bit          m_ack_seen[$];      // newest sample at the front
    bit          m_ack_late;

    initial begin
        for (int i = 0; i < c_ss; i++) m_ack_seen.push_back(1'b0);
        forever begin
            @(posedge clk or posedge arst);
            if (arst) begin
                m_phase = 0; m_word = 32'h0; m_done = 1'b0; m_err = 1'b0; m_req_cycles = 0;
                foreach (m_ack_seen[i]) m_ack_seen[i] = 1'b0;
            end else begin
                m_ack_late = m_ack_seen[c_ss-1];
                m_done     = 1'b0;
                if (m_phase == 0) begin
                    if (in_valid && !m_ack_late) begin
                        m_word = in_data; m_phase = 1; m_req_cycles = 0;
                    end
                end else if (m_phase == 1) begin
                    m_req_cycles++;
                    if (m_ack_late) m_phase = 2;
                    else if (c_to_en && m_req_cycles >= c_to) begin
                        m_phase = 2; m_err = 1'b1;
                    end
                end else begin
                    if (!m_ack_late) begin m_phase = 0; m_done = 1'b1; end
                end
                m_ack_seen.push_front(xfer_ack_async);
                void'(m_ack_seen.pop_back());
            end
        end
    end

    // Compare every output against the model away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("in_ready",    {31'b0, in_ready},    {31'b0, m_phase == 0});
            check("xfer_req",    {31'b0, xfer_req},    {31'b0, m_phase == 1});
            check("xfer_data",   xfer_data,            m_word);
            check("done",        {31'b0, done},        {31'b0, m_done});
            check("timeout_err", {31'b0, timeout_err}, {31'b0, m_err});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: one step = one negedge; optional random producer and
    // a destination-side responder that also emits spurious idle ack pulses.
    // ------------------------------------------------------------------
    bit resp_en  = 1'b0;
    bit prod_en  = 1'b0;
    int rs       = 0;
    int rdly     = 0;
    int done_cnt = 0;

    task automatic step();
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        if (prod_en) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_data  = $urandom;
        end
        if (resp_en) begin
            case (rs)
                0: if (xfer_req) begin rdly = $urandom_range(0, 4); rs = 1; end
                   else if ($urandom_range(0, 19) == 0) begin xfer_ack_async = 1'b1; rs = 4; end
                1: if (rdly == 0) begin xfer_ack_async = 1'b1; rs = 2; end else rdly--;
                2: if (!xfer_req) begin rdly = $urandom_range(0, 4); rs = 3; end
                3: if (rdly == 0) begin xfer_ack_async = 1'b0; rs = 0; end else rdly--;
                default: begin xfer_ack_async = 1'b0; rs = 0; end
            endcase
        end
    endtask

    // Step until xfer_req (sel 0) or done (sel 1) equals lvl, bounded
    task automatic wait_sig(input int sel, input logic lvl, input int limit,
                            input string name, output int when_o);
        int   n = 0;
        logic cur;
        cur = (sel == 0) ? xfer_req : done;
        while (cur !== lvl && n < limit) begin
            step();
            n++;
            cur = (sel == 0) ? xfer_req : done;
        end
        check(name, {31'b0, cur}, {31'b0, lvl});
        when_o = cyc;
    endtask

    task automatic resp_off();
        resp_en = 1'b0; rs = 0; xfer_ack_async = 1'b0;
        repeat (c_ss + 2) step();
    endtask

    logic [31:0] sent [3];
    int t0, t1, t2, n_hi;

    initial begin
        // Reset values
        @(negedge clk);
        check("rst_in_ready",    {31'b0, in_ready},    32'd1);
        check("rst_xfer_req",    {31'b0, xfer_req},    32'd0);
        check("rst_xfer_data",   xfer_data,            32'd0);
        check("rst_done",        {31'b0, done},        32'd0);
        check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        step(); step();
        arst = 1'b0;
        step();
        check("ready_after_rst", {31'b0, in_ready}, 32'd1);

        // Single transfer with a hand-driven ack
        in_valid = 1'b1; in_data = 32'hDEADBEEF; t0 = cyc;
        step();
        in_valid = 1'b0; in_data = 32'h0;
        check("t1_req_rise", {31'b0, xfer_req}, 32'd1);
        check("t1_req_lat",  32'(cyc - t0), 32'd1);
        step();
        xfer_ack_async = 1'b1; t0 = cyc;
        wait_sig(0, 1'b0, 20, "t1_req_fall", t1);
        check("t1_fall_lat",  32'(t1 - t0), 32'd4);
        check("t1_data_hold", xfer_data, 32'hDEADBEEF);
        step();
        xfer_ack_async = 1'b0; t0 = cyc;
        wait_sig(1, 1'b1, 20, "t1_done", t1);
        check("t1_done_lat", 32'(t1 - t0), 32'd4);
        step();

        // Back-to-back words with valid held high
        done_cnt = 0; rs = 0; resp_en = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            in_valid = 1'b1; in_data = 32'(w);
            wait_sig(0, 1'b1, 60, "t2_req_rise", t1);
            sent[w-1] = xfer_data;
            check("t2_not_ready", {31'b0, in_ready}, 32'd0);
            if (w == 3) in_valid = 1'b0;
            wait_sig(0, 1'b0, 60, "t2_req_fall", t1);
        end
        for (int i = 0; i < 60 && done_cnt < 3; i++) step();
        check("t2_done_count", 32'(done_cnt), 32'd3);
        check("t2_word0", sent[0], 32'h1);
        check("t2_word1", sent[1], 32'h2);
        check("t2_word2", sent[2], 32'h3);
        resp_off();

        // Stale ack after reset blocks the accept
        arst = 1'b1; step(); step();
        arst = 1'b0; xfer_ack_async = 1'b1;
        repeat (5) step();
        in_valid = 1'b1; in_data = 32'hA5A50003; n_hi = 0;
        repeat (6) begin step(); if (xfer_req) n_hi++; end
        check("t3_blocked", 32'(n_hi), 32'd0);
        xfer_ack_async = 1'b0; t0 = cyc;
        wait_sig(0, 1'b1, 20, "t3_req_rise", t1);
        check("t3_accept_lat", 32'(t1 - t0), 32'd4);
        check("t3_data", xfer_data, 32'hA5A50003);
        in_valid = 1'b0;
        step(); xfer_ack_async = 1'b1;
        wait_sig(0, 1'b0, 20, "t3_req_fall", t1);
        step(); xfer_ack_async = 1'b0;
        wait_sig(1, 1'b1, 20, "t3_done", t1);
        step();

        // Reset in the middle of REQ
        in_valid = 1'b1; in_data = 32'h12345678;
        wait_sig(0, 1'b1, 20, "t4_req_rise", t1);
        in_valid = 1'b0;
        step();
        done_cnt = 0;
        arst = 1'b1;
        #1;
        check("t4_req_abort",  {31'b0, xfer_req}, 32'd0);
        check("t4_data_clear", xfer_data,         32'd0);
        check("t4_ready",      {31'b0, in_ready}, 32'd1);
        step(); step();
        arst = 1'b0;
        step();
        check("t4_ready_after", {31'b0, in_ready}, 32'd1);
        repeat (8) step();
        check("t4_no_done", 32'(done_cnt), 32'd0);

        // Watchdog (or indefinite wait when the watchdog is compiled out)
        in_valid = 1'b1; in_data = 32'hCAFE0005;
        wait_sig(0, 1'b1, 20, "t5_req_rise", t0);
        in_valid = 1'b0;
`ifdef CDC_SENDER_TIMEOUT_EN
        wait_sig(0, 1'b0, 40, "t5_req_drop", t1);
        check("t5_req_cycles", 32'(t1 - t0), 32'd16);
        check("t5_err_set", {31'b0, timeout_err}, 32'd1);
        wait_sig(1, 1'b1, 5, "t5_done", t2);
        check("t5_done_lat", 32'(t2 - t1), 32'd1);
        rs = 0; resp_en = 1'b1;
        in_valid = 1'b1; in_data = 32'h00000055;
        wait_sig(0, 1'b1, 20, "t5_next_req", t1);
        check("t5_next_data", xfer_data, 32'h00000055);
        in_valid = 1'b0;
        wait_sig(1, 1'b1, 40, "t5_next_done", t1);
        check("t5_err_sticky", {31'b0, timeout_err}, 32'd1);
        resp_off();
`else
        repeat (40) step();
        check("t5_req_waits", {31'b0, xfer_req},    32'd1);
        check("t5_no_err",    {31'b0, timeout_err}, 32'd0);
        xfer_ack_async = 1'b1;
        wait_sig(0, 1'b0, 20, "t5_req_fall", t1);
        step(); xfer_ack_async = 1'b0;
        wait_sig(1, 1'b1, 20, "t5_done", t1);
        step();
`endif

        // Randomized traffic against the model
        done_cnt = 0; rs = 0; resp_en = 1'b1; prod_en = 1'b1;
        repeat (3000) step();
        prod_en = 1'b0; in_valid = 1'b0;
        repeat (60) step();
        check("rand_activity", {31'b0, done_cnt > 50}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
